scrolling_seg_display: RTL and testbench
========================================

// Module: scrolling_seg_display
// PURPOSE
//  Parametrised multiplexed 7-segment driver with a writable message buffer and automatic
//  scrolling. Time-multiplexes NUM_DIGITS common-anode digits with a blanking guard before
//  each digit, and rotates a MSG_LEN-entry hex message across the display every SCROLL_FRAMES
//  frames, in either direction. Sits between the board pins and user logic that loads characters.
// PARAMETERS
//  NUM_DIGITS     4   digits driven; an[NUM_DIGITS-1] is the leftmost
//  MSG_LEN        16  message entries, 4-bit each; MSG_LEN >= NUM_DIGITS
//  SCAN_DIV       16  clk cycles per scan tick (>=1)
//  STEPS_PER_DIG  4   scan ticks per digit slot (> GUARD)
//  GUARD          1   leading ticks of each slot with all anodes off (>=1)
//  SCROLL_FRAMES  64  complete frames per scroll step (>=1)
//  AW             $clog2(MSG_LEN) (derived localparam, not overridable)
// PORTS
//  clk        in   1        system clock
//  reset      in   1        asynchronous, active-high reset
//  enable     in   1        1 = scan/scroll run; 0 = display blank, scan restarts
//  dir        in   1        0 = scroll left (scroll_pos+1), 1 = scroll right (scroll_pos-1)
//  pause      in   1        1 = hold scroll_pos; scanning continues
//  load_we    in   1        message write strobe, one entry per clk
//  load_addr  in   AW       message write address (>= MSG_LEN ignored)
//  load_data  in   4        message write data (hex code)
//  an         out  NUM_DIGITS  anodes, active low
//  seg        out  7        {a,b,c,d,e,f,g}, active low
//  dp         out  1        decimal point, active low
//  scroll_pos out  AW       message index shown on leftmost digit
//  frame_done out  1        1-clk pulse at end of each full frame
// BEHAVIOUR
//  - Reset (async): an all 1, seg 7'h7F, dp 1, frame_done 0, scroll_pos 0, all counters 0,
//    msg[i] = i mod 16. Reset mid-frame blanks outputs immediately, no clk edge needed.
//  - Prescaler counts 0..SCAN_DIV-1; tick = (count==SCAN_DIV-1) & enable. Tick is an enable only.
//  - Scan state: slot index s (0..NUM_DIGITS-1, s=0 is leftmost), phase p (0..STEPS_PER_DIG-1),
//    both advancing on tick. Driven digit k = NUM_DIGITS-1-s.
//  - Phase 0: latch char = msg[(scroll_pos + s) mod MSG_LEN]. Phases < GUARD: an all 1.
//    Phases >= GUARD: an[k]=0, others 1. seg = decode(char) throughout the slot.
//  - All outputs registered: they change on the clk edge where tick is high (1 clk after
//    prescaler terminal count).
//  - End of frame (s=NUM_DIGITS-1, p=STEPS_PER_DIG-1, tick): s,p -> 0; frame_done=1 for 1 clk;
//    frame counter++; at SCROLL_FRAMES-1 it wraps to 0 and, if pause=0, scroll_pos steps
//    +1 (dir=0) or -1 (dir=1) mod MSG_LEN (15->0, 0->15 at MSG_LEN=16). Scroll only at frame boundary.
//  - pause=1 at boundary: frame counter still wraps, scroll_pos held.
//  - dp = 0 only while pause=1 and rightmost digit (k=0) is active; else 1.
//  - load_we: msg[load_addr] <= load_data next edge. A write to an entry already latched for the
//    current slot takes effect at its next latch. Write and latch of the same address on the same
//    edge: latch takes the old value.
//  - enable=0: prescaler, s, p forced 0; an all 1, dp 1; frame counter and scroll_pos held;
//    loads still accepted. On enable=1 the frame restarts at slot 0 phase 0.
//  - Decode (active low) 0-F: 01,4F,12,06,4C,24,20,0F,00,04,08,60,31,42,30,38 (hex, 7-bit).
// TESTING  (NUM_DIGITS=4, MSG_LEN=16, SCAN_DIV=2, STEPS_PER_DIG=4, GUARD=1, SCROLL_FRAMES=2)
//  1 reset, enable=1 -> per slot: 1 tick an=1111, then 3 ticks an=0111,1011,1101,1110 with seg
//    01,4F,12,06 (chars 0..3); frame_done pulses every 32 clks.
//  2 run 2 frames, dir=0 -> scroll_pos=1, leftmost '1' (4F), rightmost '4' (4C); after 32 frames
//    scroll_pos=0 again (wrap).
//  3 reset, dir=1, 2 frames -> scroll_pos=15, digits show F,0,1,2 (38,01,4F,12).
//  4 pause=1 for 10 frames -> scroll_pos constant, frame_done keeps pulsing, dp=0 only with an=1110.
//  5 mid-frame write addr 2 data A (scroll_pos=0) -> next frame slot 2 (an=1101) seg=08; same-edge
//    write/latch to addr 2 shows old value this frame.
//  6 assert reset mid-slot (no clk edge) -> an=1111, seg=7F, dp=1 at once; enable=0 mid-frame ->
//    blank, release -> resumes at slot 0 with scroll_pos unchanged.

Source files
------------

// File: rtl/scrolling_seg_display.sv
// Multiplexed common-anode 7-segment driver with a writable
// hex message buffer that scrolls across the digits.
module scrolling_seg_display #(
    parameter int NUM_DIGITS    = 4,
    parameter int MSG_LEN       = 16,
    parameter int SCAN_DIV      = 16,
    parameter int STEPS_PER_DIG = 4,
    parameter int GUARD         = 1,
    parameter int SCROLL_FRAMES = 64,
    localparam int AW           = $clog2(MSG_LEN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  dir,
    input  logic                  pause,
    input  logic                  load_we,
    input  logic [AW-1:0]         load_addr,
    input  logic [3:0]            load_data,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [AW-1:0]         scroll_pos,
    output logic                  frame_done
);

    localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PHW = $clog2(STEPS_PER_DIG);
    localparam int FW  = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

    logic [PW-1:0]         presc;
    logic [SW-1:0]         slot;
    logic [PHW-1:0]        phase;
    logic [FW-1:0]         frame_cnt;
    logic [3:0]            msg [MSG_LEN];
    logic [3:0]            char_q;
    logic                  tick;
    logic                  last_slot;
    logic                  last_phase;
    logic                  in_guard;
    logic                  addr_ok;
    logic [AW:0]           idx_sum;
    logic [AW-1:0]         idx;
    logic [3:0]            cur_char;
    logic [SW-1:0]         dig;
    logic [NUM_DIGITS-1:0] an_n;
    logic                  dp_n;

    function automatic logic [6:0] decode(input logic [3:0] c);
        logic [6:0] s;
        unique case (c)
            4'h0: s = 7'h01;
            4'h1: s = 7'h4F;
            4'h2: s = 7'h12;
            4'h3: s = 7'h06;
            4'h4: s = 7'h4C;
            4'h5: s = 7'h24;
            4'h6: s = 7'h20;
            4'h7: s = 7'h0F;
            4'h8: s = 7'h00;
            4'h9: s = 7'h04;
            4'hA: s = 7'h08;
            4'hB: s = 7'h60;
            4'hC: s = 7'h31;
            4'hD: s = 7'h42;
            4'hE: s = 7'h30;
            default: s = 7'h38;
        endcase
        return s;
    endfunction

    assign tick       = (presc == PW'(SCAN_DIV - 1)) && enable;
    assign last_slot  = (slot == SW'(NUM_DIGITS - 1));
    assign last_phase = (phase == PHW'(STEPS_PER_DIG - 1));
    assign in_guard   = (phase < PHW'(GUARD));
    assign dig        = SW'(NUM_DIGITS - 1) - slot;

    if (MSG_LEN == (1 << AW)) begin : g_full
        assign addr_ok = 1'b1;
    end else begin : g_part
        assign addr_ok = (load_addr < AW'(MSG_LEN));
    end

    // Message index for the current slot, wrapped into the buffer
    always_comb begin
        idx_sum = {1'b0, scroll_pos} + (AW + 1)'(slot);
        if (idx_sum >= (AW + 1)'(MSG_LEN))
            idx_sum = idx_sum - (AW + 1)'(MSG_LEN);
        idx = idx_sum[AW-1:0];
    end

    // Next anode / dp pattern and the character shown in this slot
    always_comb begin
        an_n = '1;
        if (!in_guard)
            an_n[dig] = 1'b0;
        dp_n     = !(pause && last_slot && !in_guard);
        cur_char = (phase == '0) ? msg[idx] : char_q;
    end

    // Scan prescaler, held at zero while disabled
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            presc <= '0;
        else if (!enable || tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end

    // Slot/phase walk across the digits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot  <= '0;
            phase <= '0;
        end else if (!enable) begin
            slot  <= '0;
            phase <= '0;
        end else if (tick) begin
            if (last_phase) begin
                phase <= '0;
                slot  <= last_slot ? '0 : slot + 1'b1;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

    // Frame counting, frame pulse and scroll stepping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt  <= '0;
            scroll_pos <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (tick && last_slot && last_phase) begin
                frame_done <= 1'b1;
                if (frame_cnt == FW'(SCROLL_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    if (!pause) begin
                        if (!dir)
                            scroll_pos <= (scroll_pos == AW'(MSG_LEN - 1)) ?
                                          '0 : scroll_pos + 1'b1;
                        else
                            scroll_pos <= (scroll_pos == '0) ?
                                          AW'(MSG_LEN - 1) : scroll_pos - 1'b1;
                    end
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Registered pin drive; character latched at the start of each slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an     <= '1;
            seg    <= 7'h7F;
            dp     <= 1'b1;
            char_q <= '0;
        end else if (!enable) begin
            an <= '1;
            dp <= 1'b1;
        end else if (tick) begin
            an     <= an_n;
            seg    <= decode(cur_char);
            dp     <= dp_n;
            char_q <= cur_char;
        end
    end

    // Message buffer; a same-edge latch still sees the old entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++)
                msg[i] <= 4'(i % 16);
        end else if (load_we && addr_ok) begin
            msg[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_scrolling_seg_display.sv
// Self-checking bench for scrolling_seg_display: directed steps
// plus random loads/dir/pause against a frame-level model.
module tb_scrolling_seg_display;

    localparam int ND = 4;
    localparam int ML = 16;
    localparam int GD = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          dir;
    logic          pause;
    logic          load_we;
    logic [3:0]    load_addr;
    logic [3:0]    load_data;
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    scroll_pos;
    logic          frame_done;

    scrolling_seg_display #(
        .NUM_DIGITS(ND), .MSG_LEN(ML), .SCAN_DIV(2),
        .STEPS_PER_DIG(4), .GUARD(GD), .SCROLL_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .dir(dir),
        .pause(pause), .load_we(load_we), .load_addr(load_addr),
        .load_data(load_data), .an(an), .seg(seg), .dp(dp),
        .scroll_pos(scroll_pos), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] DEC [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24,
                             7'h20, 7'h0F, 7'h00, 7'h04, 7'h08, 7'h60,
                             7'h31, 7'h42, 7'h30, 7'h38};

    int         checks = 0;
    int         errors = 0;
    logic [3:0] mmsg [16];
    int         pos, frames, ms, mp;
    logic [3:0] lat;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp, exp_fd, seg_valid, wr_on;
    logic [6:0] seen [4];
    int         p0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_load();
        if (wr_on && $urandom_range(0, 3) == 0) begin
            load_we   = 1'b1;
            load_addr = 4'($urandom);
            load_data = 4'($urandom);
        end else begin
            load_we = 1'b0;
        end
    endtask

    task automatic check_pins();
        chk("an", 32'(an), 32'(exp_an));
        if (seg_valid) chk("seg", 32'(seg), 32'(exp_seg));
        chk("dp", 32'(dp), 32'(exp_dp));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        chk("scroll_pos", 32'(scroll_pos), 32'(pos));
    endtask

    task automatic edge_step(input bit is_tick);
        int         cs, cp;
        logic [3:0] one;
        cs = ms;
        cp = mp;
        @(posedge clk);
        if (is_tick) begin
            if (mp == 0) lat = mmsg[(pos + ms) % ML];
            exp_seg   = DEC[lat];
            seg_valid = 1'b1;
            one       = 4'b0001 << (ND - 1 - ms);
            exp_an    = (mp < GD) ? 4'hF : ~one;
            exp_dp    = !(pause && ms == ND - 1 && mp >= GD);
            exp_fd    = (ms == ND - 1 && mp == 3);
            if (exp_fd) begin
                frames++;
                if (frames % 2 == 0 && !pause)
                    pos = dir ? (pos + ML - 1) % ML : (pos + 1) % ML;
            end
            if (mp == 3) begin
                mp = 0;
                ms = (ms + 1) % ND;
            end else begin
                mp++;
            end
        end else begin
            exp_fd = 1'b0;
        end
        if (load_we) mmsg[load_addr] = load_data;
        @(negedge clk);
        check_pins();
        if (is_tick && cp == 1) seen[cs] = seg;
        drive_load();
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            edge_step(1'b0);
            edge_step(1'b1);
        end
    endtask

    task automatic run_frames(input int n);
        run_ticks(16 * n);
    endtask

    task automatic off_step();
        @(posedge clk);
        if (load_we) mmsg[load_addr] = load_data;
        exp_an = 4'hF;
        exp_dp = 1'b1;
        exp_fd = 1'b0;
        @(negedge clk);
        check_pins();
        drive_load();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        enable  = 1'b0;
        load_we = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) mmsg[i] = 4'(i);
        pos       = 0;
        frames    = 0;
        ms        = 0;
        mp        = 0;
        lat       = '0;
        exp_an    = 4'hF;
        exp_seg   = 7'h7F;
        exp_dp    = 1'b1;
        exp_fd    = 1'b0;
        seg_valid = 1'b1;
        check_pins();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b0;
        dir       = 1'b0;
        pause     = 1'b0;
        load_we   = 1'b0;
        load_addr = '0;
        load_data = '0;
        wr_on     = 1'b0;
        @(negedge clk);

        // reset state, first frame shows chars 0..3
        do_reset();
        enable = 1'b1;
        run_frames(1);
        chk("t1_d3", 32'(seen[0]), 32'h01);
        chk("t1_d2", 32'(seen[1]), 32'h4F);
        chk("t1_d1", 32'(seen[2]), 32'h12);
        chk("t1_d0", 32'(seen[3]), 32'h06);

        // left scroll and wrap after 32 frames
        run_frames(1);
        chk("t2_pos1", 32'(scroll_pos), 32'd1);
        run_frames(1);
        chk("t2_left", 32'(seen[0]), 32'h4F);
        chk("t2_right", 32'(seen[3]), 32'h4C);
        run_frames(29);
        chk("t2_wrap", 32'(scroll_pos), 32'd0);

        // right scroll from 0 wraps to 15
        do_reset();
        dir    = 1'b1;
        enable = 1'b1;
        run_frames(2);
        chk("t3_pos15", 32'(scroll_pos), 32'd15);
        run_frames(1);
        chk("t3_d3", 32'(seen[0]), 32'h38);
        chk("t3_d2", 32'(seen[1]), 32'h01);
        chk("t3_d1", 32'(seen[2]), 32'h4F);
        chk("t3_d0", 32'(seen[3]), 32'h12);

        // pause holds position, frames keep running
        pause = 1'b1;
        p0    = pos;
        run_frames(10);
        chk("t4_hold", 32'(scroll_pos), 32'(p0));
        pause = 1'b0;

        // same-edge write/latch, then new value next frame
        do_reset();
        dir    = 1'b0;
        enable = 1'b1;
        run_ticks(8);
        edge_step(1'b0);
        load_we   = 1'b1;
        load_addr = 4'd2;
        load_data = 4'hA;
        edge_step(1'b1);
        run_ticks(7);
        chk("t5_old", 32'(seen[2]), 32'h12);
        run_frames(1);
        chk("t5_new", 32'(seen[2]), 32'h08);

        // async reset mid-slot
        run_ticks(6);
        do_reset();

        // enable low mid-frame, then restart at slot 0
        wr_on  = 1'b1;
        enable = 1'b1;
        run_frames(2);
        run_ticks(7);
        enable    = 1'b0;
        seg_valid = 1'b0;
        for (int i = 0; i < 5; i++) off_step();
        enable = 1'b1;
        ms     = 0;
        mp     = 0;
        run_frames(2);

        // random direction, pause and loads
        for (int f = 0; f < 20; f++) begin
            dir   = 1'($urandom);
            pause = ($urandom_range(0, 3) == 0);
            run_frames(1);
        end
        pause = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
